// File: rtl/led_pkg.sv
// Shared types and defaults for the breathing-LED block.
package led_pkg;

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    HOLD_HIGH = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD_LOW  = 2'd3
  } phase_e;

  localparam int unsigned DefPwmBits   = 8;
  localparam int unsigned DefHoldTicks = 16;

  // A single hold tick still needs a 1-bit counter.
  function automatic int unsigned hold_cnt_width(int unsigned ticks);
    return ($clog2(ticks) < 1) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with a registered duty compare.
module pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] r_cnt;
  logic                r_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (!en) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
      r_out <= (r_cnt < duty);
    end
  end

  assign pwm_out = r_out;

endmodule

// File: rtl/led_breath.sv
// Breathing LED: ramps PWM duty up, holds, ramps down, holds, one step per tick strobe.
module led_breath
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS   = DefPwmBits,
  parameter int unsigned HOLD_TICKS = DefHoldTicks
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                step_tick,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          phase
);

  localparam int unsigned         HoldW    = hold_cnt_width(HOLD_TICKS);
  localparam logic [PWM_BITS-1:0] Max      = '1;
  localparam logic [PWM_BITS-1:0] MaxM1    = Max - PWM_BITS'(1);
  localparam logic [HoldW-1:0]    HoldLast = HoldW'(HOLD_TICKS - 1);

  phase_e              r_phase, w_phase_d;
  logic [PWM_BITS-1:0] r_duty, w_duty_d;
  logic [HoldW-1:0]    r_hold, w_hold_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= RAMP_UP;
      r_duty  <= '0;
      r_hold  <= '0;
    end else begin
      r_phase <= w_phase_d;
      r_duty  <= w_duty_d;
      r_hold  <= w_hold_d;
    end
  end

  always_comb begin
    w_phase_d = r_phase;
    w_duty_d  = r_duty;
    w_hold_d  = r_hold;
    if (!en) begin
      w_phase_d = RAMP_UP;
      w_duty_d  = '0;
      w_hold_d  = '0;
    end else if (step_tick) begin
      unique case (r_phase)
        RAMP_UP: begin
          // duty==MAX cannot occur here normally; escape to the hold without wrapping
          if (r_duty == Max) begin
            w_phase_d = HOLD_HIGH;
            w_hold_d  = '0;
          end else begin
            w_duty_d = r_duty + PWM_BITS'(1);
            if (r_duty == MaxM1) begin
              w_phase_d = HOLD_HIGH;
              w_hold_d  = '0;
            end
          end
        end
        HOLD_HIGH: begin
          if (r_hold == HoldLast) begin
            w_phase_d = RAMP_DOWN;
            w_hold_d  = '0;
          end else begin
            w_hold_d = r_hold + HoldW'(1);
          end
        end
        RAMP_DOWN: begin
          if (r_duty == '0) begin
            w_phase_d = HOLD_LOW;
            w_hold_d  = '0;
          end else begin
            w_duty_d = r_duty - PWM_BITS'(1);
            if (r_duty == PWM_BITS'(1)) begin
              w_phase_d = HOLD_LOW;
              w_hold_d  = '0;
            end
          end
        end
        HOLD_LOW: begin
          if (r_hold == HoldLast) begin
            w_phase_d = RAMP_UP;
            w_hold_d  = '0;
          end else begin
            w_hold_d = r_hold + HoldW'(1);
          end
        end
      endcase
    end
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .duty   (r_duty),
    .pwm_out(led)
  );

  assign duty  = r_duty;
  assign phase = r_phase;

endmodule

// File: tb/tb_led_breath.sv
// Directed bench for led_breath with PWM_BITS=4, HOLD_TICKS=2.
module tb_led_breath;

  localparam int unsigned PwmBits   = 4;
  localparam int unsigned HoldTicks = 2;
  localparam logic [1:0] PhUp = 2'd0, PhHigh = 2'd1, PhDown = 2'd2, PhLow = 2'd3;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               en = 1'b0;
  logic               step_tick = 1'b0;
  logic               led;
  logic [PwmBits-1:0] duty;
  logic [1:0]         phase;

  int n_checks = 0;
  int n_errors = 0;

  led_breath #(
    .PWM_BITS  (PwmBits),
    .HOLD_TICKS(HoldTicks)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .step_tick(step_tick),
    .led      (led),
    .duty     (duty),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  // Drive inputs, take one clock edge, then settle 1 time unit past it.
  task automatic cyc(input logic e, input logic t);
    en = e;
    step_tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    step_tick = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    // Run partway so reset has something to clear, then assert it between edges.
    repeat (6) cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (duty !== 4'd0 || phase !== PhUp || led !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: duty=%0d phase=%0d led=%b, want 0 0 0", duty, phase, led);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_ramp_up();
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
      n_checks++;
      if (duty !== 4'(i)) begin
        n_errors++;
        $display("FAIL ramp_up_duty: tick %0d duty=%0d want %0d", i, duty, i);
      end
    end
    n_checks++;
    if (phase !== PhHigh) begin
      n_errors++;
      $display("FAIL ramp_up_to_hold: phase=%0d want %0d", phase, PhHigh);
    end
    cyc(1'b1, 1'b1);
    n_checks++;
    if (phase !== PhHigh || duty !== 4'd15) begin
      n_errors++;
      $display("FAIL hold_high_mid: phase=%0d duty=%0d want 1 15", phase, duty);
    end
    cyc(1'b1, 1'b1);
    n_checks++;
    if (phase !== PhDown || duty !== 4'd15) begin
      n_errors++;
      $display("FAIL hold_high_exit: phase=%0d duty=%0d want 2 15", phase, duty);
    end
  endtask

  task automatic test_full_cycle();
    do_reset();
    repeat (31) cyc(1'b1, 1'b1);
    n_checks++;
    if (phase !== PhDown || duty !== 4'd1) begin
      n_errors++;
      $display("FAIL full_t31: phase=%0d duty=%0d want 2 1", phase, duty);
    end
    cyc(1'b1, 1'b1);
    n_checks++;
    if (phase !== PhLow || duty !== 4'd0) begin
      n_errors++;
      $display("FAIL full_t32: phase=%0d duty=%0d want 3 0", phase, duty);
    end
    cyc(1'b1, 1'b1);
    n_checks++;
    if (phase !== PhLow || duty !== 4'd0) begin
      n_errors++;
      $display("FAIL full_t33: phase=%0d duty=%0d want 3 0", phase, duty);
    end
    cyc(1'b1, 1'b1);
    n_checks++;
    if (phase !== PhUp || duty !== 4'd0) begin
      n_errors++;
      $display("FAIL full_t34: phase=%0d duty=%0d want 0 0", phase, duty);
    end
    cyc(1'b1, 1'b1);
    n_checks++;
    if (phase !== PhUp || duty !== 4'd1) begin
      n_errors++;
      $display("FAIL full_t35: phase=%0d duty=%0d want 0 1", phase, duty);
    end
  endtask

  // Reach a frozen duty, then count led-high samples and rising edges over two periods.
  task automatic test_pwm(input int ticks, input int want_ones, input int want_rises);
    int ones;
    int rises;
    logic prev;
    do_reset();
    repeat (ticks) cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    ones = 0;
    rises = 0;
    prev = led;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b0);
      if (led === 1'b1) ones++;
      if (led === 1'b1 && prev === 1'b0) rises++;
      prev = led;
    end
    n_checks++;
    if (ones !== want_ones || rises !== want_rises) begin
      n_errors++;
      $display("FAIL pwm_duty_%0d: high=%0d rises=%0d want %0d %0d",
               ticks, ones, rises, want_ones, want_rises);
    end
  endtask

  task automatic test_enable_clear();
    do_reset();
    repeat (25) cyc(1'b1, 1'b1);
    n_checks++;
    if (phase !== PhDown || duty !== 4'd7) begin
      n_errors++;
      $display("FAIL en_setup: phase=%0d duty=%0d want 2 7", phase, duty);
    end
    cyc(1'b0, 1'b1);
    n_checks++;
    if (phase !== PhUp || duty !== 4'd0 || led !== 1'b0) begin
      n_errors++;
      $display("FAIL en_clear: phase=%0d duty=%0d led=%b want 0 0 0", phase, duty, led);
    end
    repeat (10) cyc(1'b0, 1'b1);
    n_checks++;
    if (phase !== PhUp || duty !== 4'd0 || led !== 1'b0) begin
      n_errors++;
      $display("FAIL en_ignore_ticks: phase=%0d duty=%0d led=%b want 0 0 0", phase, duty, led);
    end
    cyc(1'b1, 1'b1);
    n_checks++;
    if (phase !== PhUp || duty !== 4'd1) begin
      n_errors++;
      $display("FAIL en_restart: phase=%0d duty=%0d want 0 1", phase, duty);
    end
  endtask

  task automatic test_level_and_reset_mid_hold();
    do_reset();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    n_checks++;
    if (duty !== 4'd5 || phase !== PhUp) begin
      n_errors++;
      $display("FAIL tick_level: duty=%0d phase=%0d want 5 0", duty, phase);
    end
    repeat (11) cyc(1'b1, 1'b1);
    n_checks++;
    if (phase !== PhHigh || duty !== 4'd15) begin
      n_errors++;
      $display("FAIL mid_hold_setup: phase=%0d duty=%0d want 1 15", phase, duty);
    end
    repeat (4) cyc(1'b1, 1'b0);
    n_checks++;
    if (led !== 1'b1 && led !== 1'b0) begin
      n_errors++;
      $display("FAIL led_known: led=%b want 0 or 1", led);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (duty !== 4'd0 || phase !== PhUp || led !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_hold: duty=%0d phase=%0d led=%b want 0 0 0", duty, phase, led);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    cyc(1'b1, 1'b1);
    n_checks++;
    if (duty !== 4'd1 || phase !== PhUp) begin
      n_errors++;
      $display("FAIL after_reset_tick: duty=%0d phase=%0d want 1 0", duty, phase);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_full_cycle();
    test_pwm(5, 10, 2);
    test_pwm(0, 0, 0);
    test_pwm(15, 30, 2);
    test_enable_clear();
    test_level_and_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
